datapath_sequencer: RTL and testbench
=====================================

DATAPATH_SEQUENCER -- requirements
Module: datapath_sequencer

Interface
REQ-001 Parameter: OPW, 5, opcode width (IR[31:27]).
REQ-002 Parameter: REGW, 4, register-field width (Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15]).
REQ-003 Parameter: MEM_TIMEOUT, 15, maximum cycles waiting on mem_ready before the sequencer faults.
REQ-004 clock  in  1  single clock; all state changes on its rising edge.
REQ-005 clear  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  level; leaves IDLE and begins instruction fetch.
REQ-007 stop  in  1  level; enters HALT at the next instruction boundary.
REQ-008 ir  in  32  current IR contents.
REQ-009 mem_ready  in  1  memory read data is valid this cycle.
REQ-010 bus_sel  out  5  encoded bus-mux source select.
REQ-011 reg_in  out  16  one-hot R0..R15 load enables.
REQ-012 pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in  out  1 each  register load enables.
REQ-013 inc_pc  out  1  ALU computes PC+1 instead of alu_op.
REQ-014 mem_read  out  1  memory read request.
REQ-015 alu_op  out  5  ALU operation code.
REQ-016 run  out  1  run/halt indicator.
REQ-017 fault  out  1  sticky memory-timeout flag.

Function
REQ-018 States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALT.
REQ-019 IDLE: all enables 0, run=0; start=1 -> T0.
REQ-020 T0: bus_sel=PC, mar_in=1, inc_pc=1, z_in=1 -> T1.
REQ-021 T1: bus_sel=Z_LO, mem_read=1, mdr_in=1; pc_in=1 only in the cycle mem_ready=1; advance to T2 only on mem_ready=1, otherwise hold T1.
REQ-022 T1 timeout: a wait counter that reaches MEM_TIMEOUT without mem_ready sets fault=1 -> HALT.
REQ-023 T2: bus_sel=MDR, ir_in=1; next state is T3, except halt -> HALT and nop -> T0.
REQ-024 T3: bus_sel=Rb, y_in=1 -> T4.
REQ-025 T4: bus_sel=Rc (ignored by neg/not), alu_op=IR opcode, z_in=1 -> T5.
REQ-026 T5: bus_sel=Z_LO; ALU class asserts reg_in[Ra] and goes to T0; mul/div assert lo_in and go to T6.
REQ-027 T6: bus_sel=Z_HI, hi_in=1 -> T0.
REQ-028 Instruction boundary is any transition into T0; if stop=1 at a boundary -> HALT instead of T0.
REQ-029 HALT: all enables 0, run=0; only clear exits HALT; start is ignored.
REQ-030 run=1 in states T0..T6.
REQ-031 At most one bus_sel source and at most one reg_in bit per cycle; all outputs are decoded from registered state (Moore), except pc_in in T1.
REQ-032 An undefined opcode behaves as nop.
REQ-033 A write to R0 is permitted; no special case.

Reset
REQ-034 clear=0 asynchronously forces IDLE, all enables 0, bus_sel=0, alu_op=0, run=0, fault=0, wait counter=0, including mid-instruction and mid-wait.

Structure
REQ-035 Shared package datapath_pkg holds the state enum, opcode constants (add, sub, and, or, shl, shr, neg, not, mul, div, nop, halt), and bus_sel codes (R0..R15=0..15, HI=16, LO=17, Z_HI=18, Z_LO=19, PC=20, MDR=21, INPORT=22, C_SIGN=23).
REQ-036 One sub-module, reg_decoder_4to16, generates reg_in from a register field and an enable.

Verification
REQ-037 Reset, then start with ir=add R3,R1,R2 and mem_ready in T1 -> T0..T5 in 6 cycles; T3 bus_sel=1; T4 bus_sel=2, alu_op=add; T5 bus_sel=19 and reg_in=0x0008.
REQ-038 mul R0,R5,R6 -> T5 lo_in=1 with bus_sel=19, then T6 hi_in=1 with bus_sel=18, then T0.
REQ-039 mem_ready held 0 for 3 cycles in T1 -> T1 held 4 cycles, pc_in pulses only in the ready cycle; held 0 for 15 cycles -> fault=1, HALT, run=0.
REQ-040 stop=1 during T4 of an add -> T5 completes, then HALT; start=1 in HALT keeps HALT.
REQ-041 clear pulsed low during T3 -> outputs 0 immediately with no clock edge; IDLE after clear returns to 1.
REQ-042 ir=halt -> HALT after T2 with no reg_in asserted; ir=nop -> T2 goes directly to T0.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared definitions for the datapath control sequencer: control-step
// encoding, opcode values, bus-mux source codes and opcode classifiers.
package datapath_pkg;

    localparam int BUS_W = 5;

    typedef enum logic [3:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_HALT
    } state_t;

    // Opcode values carried in IR[31:27]; anything not listed decodes as nop.
    localparam logic [4:0] OP_ADD  = 5'h03;
    localparam logic [4:0] OP_SUB  = 5'h04;
    localparam logic [4:0] OP_AND  = 5'h05;
    localparam logic [4:0] OP_OR   = 5'h06;
    localparam logic [4:0] OP_SHR  = 5'h07;
    localparam logic [4:0] OP_SHL  = 5'h08;
    localparam logic [4:0] OP_MUL  = 5'h0F;
    localparam logic [4:0] OP_DIV  = 5'h10;
    localparam logic [4:0] OP_NEG  = 5'h11;
    localparam logic [4:0] OP_NOT  = 5'h12;
    localparam logic [4:0] OP_NOP  = 5'h1A;
    localparam logic [4:0] OP_HALT = 5'h1B;

    // Bus-mux source codes; R0..R15 occupy codes 0..15.
    localparam logic [BUS_W-1:0] SEL_HI     = 5'd16;
    localparam logic [BUS_W-1:0] SEL_LO     = 5'd17;
    localparam logic [BUS_W-1:0] SEL_Z_HI   = 5'd18;
    localparam logic [BUS_W-1:0] SEL_Z_LO   = 5'd19;
    localparam logic [BUS_W-1:0] SEL_PC     = 5'd20;
    localparam logic [BUS_W-1:0] SEL_MDR    = 5'd21;
    localparam logic [BUS_W-1:0] SEL_INPORT = 5'd22;
    localparam logic [BUS_W-1:0] SEL_C_SIGN = 5'd23;

    // Single-result ALU operations that write back into a general register.
    function automatic logic op_is_alu(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHR, OP_SHL, OP_NEG, OP_NOT: op_is_alu = 1'b1;
            default:                        op_is_alu = 1'b0;
        endcase
    endfunction

    // Double-width operations whose result lands in HI/LO.
    function automatic logic op_is_muldiv(input logic [4:0] op);
        op_is_muldiv = (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/reg_decoder_4to16.sv
// One-hot register load-enable decoder: drives exactly one bit for the
// selected register when enabled, nothing otherwise.
module reg_decoder_4to16 #(
    parameter int REGW = 4
) (
    input  logic [REGW-1:0]      field,
    input  logic                 en,
    output logic [(1<<REGW)-1:0] onehot
);

    // Decode the register field into a single load enable.
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[field] = 1'b1;
        end
    end

endmodule

// File: rtl/datapath_sequencer.sv
// Control sequencer for a bus-based datapath: steps through fetch (T0..T2)
// and execute (T3..T6) control steps, driving register load enables, the
// bus-mux select and the ALU operation. Memory fetch waits on mem_ready
// with a bounded wait that faults into HALT.
module datapath_sequencer
    import datapath_pkg::*;
#(
    parameter int OPW         = 5,
    parameter int REGW        = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 start,
    input  logic                 stop,
    input  logic [31:0]          ir,
    input  logic                 mem_ready,
    output logic [BUS_W-1:0]     bus_sel,
    output logic [(1<<REGW)-1:0] reg_in,
    output logic                 pc_in,
    output logic                 ir_in,
    output logic                 mar_in,
    output logic                 mdr_in,
    output logic                 y_in,
    output logic                 z_in,
    output logic                 hi_in,
    output logic                 lo_in,
    output logic                 inc_pc,
    output logic                 mem_read,
    output logic [OPW-1:0]       alu_op,
    output logic                 run,
    output logic                 fault
);

    localparam int                CNT_W     = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t           state_q, state_d;
    state_t           boundary_next;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic             fault_q, fault_d;

    logic [OPW-1:0]   opcode;
    logic [REGW-1:0]  ra, rb, rc;
    logic             is_alu, is_muldiv, is_halt;
    logic             reg_wr_en;
    logic             unused_ir;

    // IR field extraction; low-order immediate bits are not used here.
    assign opcode    = ir[31 -: OPW];
    assign ra        = ir[31-OPW -: REGW];
    assign rb        = ir[31-OPW-REGW -: REGW];
    assign rc        = ir[31-OPW-2*REGW -: REGW];
    assign unused_ir = ^ir[31-OPW-3*REGW:0];

    assign is_alu    = op_is_alu(5'(opcode));
    assign is_muldiv = op_is_muldiv(5'(opcode));
    assign is_halt   = (5'(opcode) == OP_HALT);

    // Every entry into T0 is an instruction boundary where stop is honoured.
    assign boundary_next = stop ? S_HALT : S_T0;

    // State, fetch-wait counter and sticky fault registers.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            fault_q <= fault_d;
        end
    end

    // Next-state logic; the wait counter only advances while stalled in T1.
    always_comb begin
        state_d = state_q;
        wait_d  = '0;
        fault_d = fault_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = boundary_next;
                end
            end
            S_T0: state_d = S_T1;
            S_T1: begin
                if (mem_ready) begin
                    state_d = S_T2;
                end else if (wait_q == WAIT_LAST) begin
                    fault_d = 1'b1;
                    state_d = S_HALT;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_T2: begin
                if (is_halt) begin
                    state_d = S_HALT;
                end else if (is_alu || is_muldiv) begin
                    state_d = S_T3;
                end else begin
                    // nop and undefined opcodes skip execution entirely
                    state_d = boundary_next;
                end
            end
            S_T3: state_d = S_T4;
            S_T4: state_d = S_T5;
            S_T5: state_d = is_muldiv ? S_T6 : boundary_next;
            S_T6: state_d = boundary_next;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore control outputs per step; pc_in in T1 follows mem_ready directly.
    always_comb begin
        bus_sel  = '0;
        pc_in    = 1'b0;
        ir_in    = 1'b0;
        mar_in   = 1'b0;
        mdr_in   = 1'b0;
        y_in     = 1'b0;
        z_in     = 1'b0;
        hi_in    = 1'b0;
        lo_in    = 1'b0;
        inc_pc   = 1'b0;
        mem_read = 1'b0;
        alu_op   = '0;
        run      = 1'b0;
        case (state_q)
            S_T0: begin
                run     = 1'b1;
                bus_sel = SEL_PC;
                mar_in  = 1'b1;
                inc_pc  = 1'b1;
                z_in    = 1'b1;
            end
            S_T1: begin
                run      = 1'b1;
                bus_sel  = SEL_Z_LO;
                mem_read = 1'b1;
                mdr_in   = 1'b1;
                pc_in    = mem_ready;
            end
            S_T2: begin
                run     = 1'b1;
                bus_sel = SEL_MDR;
                ir_in   = 1'b1;
            end
            S_T3: begin
                run     = 1'b1;
                bus_sel = BUS_W'(rb);
                y_in    = 1'b1;
            end
            S_T4: begin
                run     = 1'b1;
                bus_sel = BUS_W'(rc);
                alu_op  = opcode;
                z_in    = 1'b1;
            end
            S_T5: begin
                run     = 1'b1;
                bus_sel = SEL_Z_LO;
                lo_in   = is_muldiv;
            end
            S_T6: begin
                run     = 1'b1;
                bus_sel = SEL_Z_HI;
                hi_in   = 1'b1;
            end
            default: begin
                run = 1'b0;
            end
        endcase
    end

    assign reg_wr_en = (state_q == S_T5) && is_alu;
    assign fault     = fault_q;

    reg_decoder_4to16 #(
        .REGW (REGW)
    ) u_reg_decoder (
        .field  (ra),
        .en     (reg_wr_en),
        .onehot (reg_in)
    );

endmodule

// File: tb/tb_datapath_sequencer.sv
// Self-checking bench for datapath_sequencer: each scenario queues the
// expected per-cycle outputs with the inputs to apply, then walks the queue
// comparing the DUT against it.
module tb_datapath_sequencer;
    import datapath_pkg::*;

    localparam int IDLE = 0, T0 = 1, T1 = 2, T2 = 3, T3 = 4, T4 = 5, T5 = 6, T6 = 7, HALT = 8;

    localparam logic [31:0] IR_ADD  = {5'h03, 4'd3, 4'd1, 4'd2, 15'd0};
    localparam logic [31:0] IR_MUL  = {5'h0F, 4'd0, 4'd5, 4'd6, 15'd0};
    localparam logic [31:0] IR_NOP  = {5'h1A, 27'd0};
    localparam logic [31:0] IR_UND  = {5'h1E, 4'd7, 4'd7, 4'd7, 15'd0};
    localparam logic [31:0] IR_HALT = {5'h1B, 4'd4, 4'd4, 4'd4, 15'd0};

    typedef struct packed {
        logic [4:0]  bus_sel;
        logic [15:0] reg_in;
        logic        pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in, inc_pc, mem_read;
        logic [4:0]  alu_op;
        logic        run, fault;
    } outs_t;

    typedef struct {
        outs_t       exp;
        logic [31:0] irv;
        logic        rdy, stp, strt;
    } entry_t;

    logic        clock = 1'b0;
    logic        clear, start, stop, mem_ready;
    logic [31:0] ir;
    logic [4:0]  bus_sel;
    logic [15:0] reg_in;
    logic        pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in, inc_pc, mem_read;
    logic [4:0]  alu_op;
    logic        run, fault;
    outs_t       obs;

    entry_t q[$];
    int     errors = 0;
    int     checks = 0;

    datapath_sequencer dut (
        .clock(clock), .clear(clear), .start(start), .stop(stop), .ir(ir),
        .mem_ready(mem_ready), .bus_sel(bus_sel), .reg_in(reg_in),
        .pc_in(pc_in), .ir_in(ir_in), .mar_in(mar_in), .mdr_in(mdr_in),
        .y_in(y_in), .z_in(z_in), .hi_in(hi_in), .lo_in(lo_in),
        .inc_pc(inc_pc), .mem_read(mem_read), .alu_op(alu_op),
        .run(run), .fault(fault)
    );

    always #5 clock = ~clock;

    assign obs = {bus_sel, reg_in, pc_in, ir_in, mar_in, mdr_in, y_in, z_in,
                  hi_in, lo_in, inc_pc, mem_read, alu_op, run, fault};

    // Expected outputs for a control step, built from the step table.
    function automatic outs_t exp_of(int st, logic [31:0] irv, logic rdy, logic flt);
        outs_t      o;
        logic [4:0] op;
        o = '0;
        op = irv[31:27];
        o.fault = flt;
        o.run = (st >= T0 && st <= T6);
        case (st)
            T0: begin o.bus_sel = 5'd20; o.mar_in = 1'b1; o.inc_pc = 1'b1; o.z_in = 1'b1; end
            T1: begin o.bus_sel = 5'd19; o.mem_read = 1'b1; o.mdr_in = 1'b1; o.pc_in = rdy; end
            T2: begin o.bus_sel = 5'd21; o.ir_in = 1'b1; end
            T3: begin o.bus_sel = {1'b0, irv[22:19]}; o.y_in = 1'b1; end
            T4: begin o.bus_sel = {1'b0, irv[18:15]}; o.alu_op = op; o.z_in = 1'b1; end
            T5: begin
                o.bus_sel = 5'd19;
                if (op == OP_MUL || op == OP_DIV) o.lo_in = 1'b1;
                else o.reg_in[irv[26:23]] = 1'b1;
            end
            T6: begin o.bus_sel = 5'd18; o.hi_in = 1'b1; end
            default: ;
        endcase
        return o;
    endfunction

    function automatic void push(int st, logic [31:0] irv, logic rdy, logic stp, logic strt, logic flt);
        entry_t e;
        e.exp  = exp_of(st, irv, rdy, flt);
        e.irv  = irv;
        e.rdy  = rdy;
        e.stp  = stp;
        e.strt = strt;
        q.push_back(e);
    endfunction

    task automatic do_reset();
        @(negedge clock);
        clear = 1'b0; start = 1'b0; stop = 1'b0; mem_ready = 1'b0;
        #2 clear = 1'b1;
    endtask

    task automatic test_reset();
        entry_t e;
        clear = 1'b0; start = 1'b1; stop = 1'b0; mem_ready = 1'b1; ir = IR_ADD;
        repeat (2) @(negedge clock);
        #1;
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL reset_hold got %h expected %h", obs, outs_t'('0)); end
        clear = 1'b1; start = 1'b0; mem_ready = 1'b0;
        push(IDLE, IR_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
        push(IDLE, IR_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int n = 0; q.size() > 0; n++) begin
            e = q.pop_front();
            @(negedge clock);
            ir = e.irv; mem_ready = e.rdy; stop = e.stp; start = e.strt;
            #1;
            checks++;
            if (obs !== e.exp) begin errors++; $display("FAIL reset_idle step %0d got %h expected %h", n, obs, e.exp); end
        end
    endtask

    task automatic test_add();
        entry_t e;
        do_reset();
        push(IDLE, IR_ADD, 1'b0, 1'b0, 1'b1, 1'b0);
        push(T0,   IR_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
        push(T1,   IR_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
        push(T2,   IR_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
        push(T3,   IR_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
        push(T4,   IR_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
        push(T5,   IR_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
        push(T0,   IR_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int n = 0; q.size() > 0; n++) begin
            e = q.pop_front();
            @(negedge clock);
            ir = e.irv; mem_ready = e.rdy; stop = e.stp; start = e.strt;
            #1;
            checks++;
            if (obs !== e.exp) begin errors++; $display("FAIL add step %0d got %h expected %h", n, obs, e.exp); end
        end
    endtask

    task automatic test_mul();
        entry_t e;
        do_reset();
        push(IDLE, IR_MUL, 1'b0, 1'b0, 1'b1, 1'b0);
        push(T0,   IR_MUL, 1'b0, 1'b0, 1'b0, 1'b0);
        push(T1,   IR_MUL, 1'b1, 1'b0, 1'b0, 1'b0);
        push(T2,   IR_MUL, 1'b0, 1'b0, 1'b0, 1'b0);
        push(T3,   IR_MUL, 1'b0, 1'b0, 1'b0, 1'b0);
        push(T4,   IR_MUL, 1'b0, 1'b0, 1'b0, 1'b0);
        push(T5,   IR_MUL, 1'b0, 1'b0, 1'b0, 1'b0);
        push(T6,   IR_MUL, 1'b0, 1'b0, 1'b0, 1'b0);
        push(T0,   IR_MUL, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int n = 0; q.size() > 0; n++) begin
            e = q.pop_front();
            @(negedge clock);
            ir = e.irv; mem_ready = e.rdy; stop = e.stp; start = e.strt;
            #1;
            checks++;
            if (obs !== e.exp) begin errors++; $display("FAIL mul step %0d got %h expected %h", n, obs, e.exp); end
        end
    endtask

    task automatic test_mem_wait();
        entry_t e;
        do_reset();
        push(IDLE, IR_NOP, 1'b0, 1'b0, 1'b1, 1'b0);
        push(T0,   IR_NOP, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) push(T1, IR_NOP, 1'b0, 1'b0, 1'b0, 1'b0);
        push(T1,   IR_NOP, 1'b1, 1'b0, 1'b0, 1'b0);
        push(T2,   IR_NOP, 1'b0, 1'b0, 1'b0, 1'b0);
        push(T0,   IR_NOP, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) push(T1, IR_NOP, 1'b0, 1'b0, 1'b0, 1'b0);
        push(HALT, IR_NOP, 1'b0, 1'b0, 1'b0, 1'b1);
        push(HALT, IR_NOP, 1'b1, 1'b0, 1'b1, 1'b1);
        for (int n = 0; q.size() > 0; n++) begin
            e = q.pop_front();
            @(negedge clock);
            ir = e.irv; mem_ready = e.rdy; stop = e.stp; start = e.strt;
            #1;
            checks++;
            if (obs !== e.exp) begin errors++; $display("FAIL mem_wait step %0d got %h expected %h", n, obs, e.exp); end
        end
    endtask

    task automatic test_stop();
        entry_t e;
        do_reset();
        push(IDLE, IR_ADD, 1'b0, 1'b0, 1'b1, 1'b0);
        push(T0,   IR_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
        push(T1,   IR_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
        push(T2,   IR_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
        push(T3,   IR_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
        push(T4,   IR_ADD, 1'b0, 1'b1, 1'b0, 1'b0);
        push(T5,   IR_ADD, 1'b0, 1'b1, 1'b0, 1'b0);
        push(HALT, IR_ADD, 1'b0, 1'b0, 1'b1, 1'b0);
        push(HALT, IR_ADD, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int n = 0; q.size() > 0; n++) begin
            e = q.pop_front();
            @(negedge clock);
            ir = e.irv; mem_ready = e.rdy; stop = e.stp; start = e.strt;
            #1;
            checks++;
            if (obs !== e.exp) begin errors++; $display("FAIL stop step %0d got %h expected %h", n, obs, e.exp); end
        end
    endtask

    task automatic test_clear_async();
        entry_t e;
        do_reset();
        push(IDLE, IR_ADD, 1'b0, 1'b0, 1'b1, 1'b0);
        push(T0,   IR_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
        push(T1,   IR_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
        push(T2,   IR_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
        push(T3,   IR_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int n = 0; q.size() > 0; n++) begin
            e = q.pop_front();
            @(negedge clock);
            ir = e.irv; mem_ready = e.rdy; stop = e.stp; start = e.strt;
            #1;
            checks++;
            if (obs !== e.exp) begin errors++; $display("FAIL clear_pre step %0d got %h expected %h", n, obs, e.exp); end
        end
        // Pulse clear between clock edges: outputs must drop without a clock.
        clear = 1'b0;
        #1;
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL clear_async got %h expected %h", obs, outs_t'('0)); end
        #1 clear = 1'b1;
        push(IDLE, IR_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
        push(IDLE, IR_ADD, 1'b0, 1'b0, 1'b1, 1'b0);
        push(T0,   IR_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int n = 0; q.size() > 0; n++) begin
            e = q.pop_front();
            @(negedge clock);
            ir = e.irv; mem_ready = e.rdy; stop = e.stp; start = e.strt;
            #1;
            checks++;
            if (obs !== e.exp) begin errors++; $display("FAIL clear_post step %0d got %h expected %h", n, obs, e.exp); end
        end
    endtask

    task automatic test_nop_halt();
        entry_t e;
        do_reset();
        push(IDLE, IR_NOP,  1'b0, 1'b0, 1'b1, 1'b0);
        push(T0,   IR_NOP,  1'b0, 1'b0, 1'b0, 1'b0);
        push(T1,   IR_NOP,  1'b1, 1'b0, 1'b0, 1'b0);
        push(T2,   IR_NOP,  1'b0, 1'b0, 1'b0, 1'b0);
        push(T0,   IR_UND,  1'b0, 1'b0, 1'b0, 1'b0);
        push(T1,   IR_UND,  1'b1, 1'b0, 1'b0, 1'b0);
        push(T2,   IR_UND,  1'b0, 1'b0, 1'b0, 1'b0);
        push(T0,   IR_HALT, 1'b0, 1'b0, 1'b0, 1'b0);
        push(T1,   IR_HALT, 1'b1, 1'b0, 1'b0, 1'b0);
        push(T2,   IR_HALT, 1'b0, 1'b0, 1'b0, 1'b0);
        push(HALT, IR_HALT, 1'b0, 1'b0, 1'b0, 1'b0);
        push(HALT, IR_HALT, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int n = 0; q.size() > 0; n++) begin
            e = q.pop_front();
            @(negedge clock);
            ir = e.irv; mem_ready = e.rdy; stop = e.stp; start = e.strt;
            #1;
            checks++;
            if (obs !== e.exp) begin errors++; $display("FAIL nop_halt step %0d got %h expected %h", n, obs, e.exp); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "simulation time limit");
    end

    initial begin
        test_reset();
        test_add();
        test_mul();
        test_mem_wait();
        test_stop();
        test_clear_async();
        test_nop_halt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
